secure_serial_receiver: RTL
===========================

Name: secure_serial_receiver

Overview:
- Parametrised successor to the system's fixed 8-bit request/confirm serial intake.
- Accepts a request/confirm handshake, then shifts in back-to-back DATA_W-bit words, MSB-first, with an optional even-parity bit per word.
- Encrypts each word by XOR with a session key; the key optionally rotates per word.
- Delivers plain and cipher words with a one-cycle valid pulse to the downstream abnormality/encryption logic.

Parameters:
- DATA_W, 8, word width in bits; key width equals DATA_W; legal range 2..32.
- PARITY_EN, 0, 1 = each word is followed by one even-parity bit.
- ROTATE_KEY, 0, 1 = active key rotates left by 1 after every accepted word.
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clock  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- request  in  1  host requests a session; must stay high for the whole session.
- confirm  in  1  host confirms the session; sampled in ARMED and at word end.
- inputdata  in  1  serial data bit, sampled on each rising clock edge in RECV.
- key  in  DATA_W  session key, latched on the ARMED->RECV transition.
- data_out  out  DATA_W  last received plaintext word.
- cipher_out  out  DATA_W  data_out XOR active key.
- data_valid  out  1  one-cycle pulse when a new word is presented.
- parity_err  out  1  one-cycle pulse when a word fails parity (PARITY_EN=1 only).
- abort  out  1  one-cycle pulse when request drops mid-word.
- word_count  out  CNT_W  accepted words since reset; wraps to 0.
- busy  out  1  high in ARMED and RECV.

Behaviour:
- Reset (async, immediate): state=IDLE; all outputs 0; shift register, bit counter and active key cleared.
- States: IDLE, ARMED, RECV.
- IDLE: request=1 -> ARMED. Otherwise stay in IDLE.
- ARMED:
  - request=0 -> IDLE, no pulse.
  - request=1 and confirm=1 -> RECV; latch key into the active key; bit counter=0. No data bit is sampled on this edge.
  - Otherwise stay in ARMED.
- RECV, each edge with request=1: shift inputdata into the LSB (MSB-first word); increment the bit counter. Frame length is DATA_W+PARITY_EN.
- Final bit edge of a word:
  - Parity check applies when PARITY_EN=1: XOR of the data bits and the parity bit must be 0.
  - Good word: on the same edge, data_out=word, cipher_out=word^active_key, data_valid=1 for the next cycle, word_count+1.
  - If ROTATE_KEY=1, the active key rotates left after cipher_out is computed, so the next word uses the rotated key.
  - Bad parity: parity_err pulses; data_out, cipher_out, data_valid and word_count are unchanged; the key does not rotate.
  - Bit counter resets to 0.
  - If confirm=1, stay in RECV; the next edge samples bit 0 of the next word, with no gap cycle.
  - If confirm=0, go to IDLE.
- RECV with request=0 on any edge: go to IDLE; abort pulses only if the bit counter is nonzero; the partial word is discarded; outputs hold.
- data_out and cipher_out hold between words. Pulses never last more than 1 cycle.
- word_count wraps from 2^CNT_W-1 to 0.
- Latency: the final data bit is sampled at edge N; the output is visible after edge N.
- Reset asserted mid-word drops the word; no pulse.

Decomposition:
- Package health_link_pkg holds:
  - the state enum (IDLE/ARMED/RECV);
  - a helper function for frame length (DATA_W+PARITY_EN);
  - a rotate-left function.
- One natural sub-module, serial_shift_capture, contains the shift register, bit counter, parity accumulator and frame-done strobe.
- The top module holds the FSM, key register, cipher XOR and counter.

Test Plan:
- Defaults, key=8'hE0: request=1, then confirm=1, then shift bits 0,1,0,1,0,1,0,1 -> after the 8th edge data_out=8'h55, cipher_out=8'hB5, data_valid one cycle, word_count=1.
- ROTATE_KEY=1, key=8'hE0: words 8'h55 then 8'h0F back-to-back, confirm held -> cipher 8'hB5, then 8'h0F^8'hC1=8'hCE; no gap cycle; word_count=2.
- PARITY_EN=1: word 8'h55 with parity 0 -> data_valid. Word 8'h55 with parity 1 -> parity_err pulse, data_out stays 8'h55, word_count unchanged.
- request dropped after 3 bits -> abort pulse, IDLE, busy=0. A new session then receives 8'h0F correctly.
- Async reset asserted between clock edges mid-word -> all outputs 0 immediately, state IDLE. confirm=0 at word end -> IDLE after data_valid.
- CNT_W=2: 5 words -> word_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/health_link_pkg.sv
// Shared types and helpers for the secure serial intake: FSM states, frame length and key rotation.
package health_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RECV  = 2'd2
    } rxState_t;

    function automatic int frameLen(input int dataW, input int parityEn);
        return dataW + parityEn;
    endfunction

    // Rotate the low w bits of v left by one; bits above w are forced to zero.
    function automatic logic [31:0] rotl1(input logic [31:0] v, input int w);
        logic [31:0] mask;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/secure_serial_receiver_if.sv
// Host-side handshake, serial data and key inputs plus the word/status outputs of the receiver.
interface secure_serial_receiver_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              request;
    logic              confirm;
    logic              inputdata;
    logic [DATA_W-1:0] key;
    logic [DATA_W-1:0] data_out;
    logic [DATA_W-1:0] cipher_out;
    logic              data_valid;
    logic              parity_err;
    logic              abort;
    logic [CNT_W-1:0]  word_count;
    logic              busy;

    modport master (
        output request, confirm, inputdata, key,
        input  data_out, cipher_out, data_valid, parity_err, abort, word_count, busy
    );

    modport slave (
        input  request, confirm, inputdata, key,
        output data_out, cipher_out, data_valid, parity_err, abort, word_count, busy
    );
endinterface

// File: rtl/serial_shift_capture.sv
// MSB-first shift register, bit counter and even-parity accumulator; frameDone and word are combinational
// on the final bit so the caller can register the word on that same edge. No backpressure.
import health_link_pkg::*;

module serial_shift_capture #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sampleEn,
    input  logic              clear,
    input  logic              serialIn,
    output logic [DATA_W-1:0] word,
    output logic              parityOk,
    output logic              frameDone,
    output logic              bitCntNz
);
    localparam int FRAME = frameLen(DATA_W, PARITY_EN);
    localparam int CW    = $clog2(FRAME + 1);
    // Without parity the last data bit comes straight from serialIn, so one stage fewer is stored.
    localparam int SR_W  = DATA_W - 1 + PARITY_EN;
    localparam logic [CW-1:0] LAST_BIT  = CW'(FRAME - 1);
    localparam logic [CW-1:0] DATA_BITS = CW'(DATA_W);

    logic [SR_W-1:0] shiftReg;
    logic [CW-1:0]   bitCnt;
    logic            parityAcc;
    logic            isDataBit;

    assign isDataBit = bitCnt < DATA_BITS;
    assign frameDone = sampleEn && (bitCnt == LAST_BIT);
    assign bitCntNz  = bitCnt != '0;
    assign parityOk  = (PARITY_EN == 0) || !(parityAcc ^ serialIn);

    generate
        if (PARITY_EN != 0) begin : gWordPar
            assign word = shiftReg;
        end else begin : gWordNoPar
            assign word = {shiftReg, serialIn};
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shiftReg  <= '0;
            bitCnt    <= '0;
            parityAcc <= 1'b0;
        end else if (clear) begin
            bitCnt    <= '0;
            parityAcc <= 1'b0;
        end else if (sampleEn) begin
            if (isDataBit) begin
                shiftReg  <= SR_W'({shiftReg, serialIn});
                parityAcc <= parityAcc ^ serialIn;
            end
            if (frameDone) begin
                bitCnt    <= '0;
                parityAcc <= 1'b0;
            end else begin
                bitCnt <= bitCnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/secure_serial_receiver.sv
// Request/confirm serial word receiver with XOR session-key encryption; word visible the cycle after its
// final bit edge, data_valid/parity_err/abort are single-cycle pulses, no backpressure.
import health_link_pkg::*;

module secure_serial_receiver #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int ROTATE_KEY = 0,
    parameter int CNT_W      = 8
) (
    input logic                      clock,
    input logic                      reset,
    secure_serial_receiver_if.slave  bus
);
    rxState_t          state;
    logic [DATA_W-1:0] activeKey;
    logic [DATA_W-1:0] dataOut;
    logic [DATA_W-1:0] cipherOut;
    logic              dataValid;
    logic              parityErr;
    logic              abortPulse;
    logic              busyReg;
    logic [CNT_W-1:0]  wordCount;

    logic              sampleEn;
    logic              frameDone;
    logic              parityOk;
    logic              bitCntNz;
    logic [DATA_W-1:0] capWord;

    assign sampleEn = (state == RECV) && bus.request;

    serial_shift_capture #(
        .DATA_W    (DATA_W),
        .PARITY_EN (PARITY_EN)
    ) uCapture (
        .clock     (clock),
        .reset     (reset),
        .sampleEn  (sampleEn),
        .clear     (!sampleEn),
        .serialIn  (bus.inputdata),
        .word      (capWord),
        .parityOk  (parityOk),
        .frameDone (frameDone),
        .bitCntNz  (bitCntNz)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            activeKey  <= '0;
            dataOut    <= '0;
            cipherOut  <= '0;
            dataValid  <= 1'b0;
            parityErr  <= 1'b0;
            abortPulse <= 1'b0;
            busyReg    <= 1'b0;
            wordCount  <= '0;
        end else begin
            dataValid  <= 1'b0;
            parityErr  <= 1'b0;
            abortPulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.request) begin
                        state   <= ARMED;
                        busyReg <= 1'b1;
                    end
                end
                ARMED: begin
                    if (!bus.request) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else if (bus.confirm) begin
                        state     <= RECV;
                        activeKey <= bus.key;
                    end
                end
                RECV: begin
                    if (!bus.request) begin
                        state      <= IDLE;
                        busyReg    <= 1'b0;
                        abortPulse <= bitCntNz;
                    end else if (frameDone) begin
                        if (parityOk) begin
                            dataOut   <= capWord;
                            cipherOut <= capWord ^ activeKey;
                            dataValid <= 1'b1;
                            wordCount <= wordCount + CNT_W'(1);
                            if (ROTATE_KEY != 0)
                                activeKey <= DATA_W'(rotl1(32'(activeKey), DATA_W));
                        end else begin
                            parityErr <= 1'b1;
                        end
                        if (!bus.confirm) begin
                            state   <= IDLE;
                            busyReg <= 1'b0;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    busyReg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = dataOut;
    assign bus.cipher_out = cipherOut;
    assign bus.data_valid = dataValid;
    assign bus.parity_err = parityErr;
    assign bus.abort      = abortPulse;
    assign bus.word_count = wordCount;
    assign bus.busy       = busyReg;

endmodule
